// File: rtl/lz77_pkg.sv
// rtl/lz77_pkg.sv - shared types and defaults for the LZ77 stream decoder
package lz77_pkg;

  localparam int TOK_DATA_W = 8;
  localparam int TOK_POS_W  = 5;
  localparam int TOK_LEN_W  = 5;

  localparam logic [TOK_DATA_W-1:0] END_CHAR_DEFAULT = 8'h24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [TOK_POS_W-1:0]  pos;
    logic [TOK_LEN_W-1:0]  len;
    logic [TOK_DATA_W-1:0] lit;
  } token_t;

endpackage

// File: rtl/lz77_stream_decoder_if.sv
// rtl/lz77_stream_decoder_if.sv - token input and character output handshake bundle
interface lz77_stream_decoder_if #(
  parameter int DATA_W = 8,
  parameter int POS_W  = 5,
  parameter int LEN_W  = 5
);
  logic              code_valid;
  logic              code_ready;
  logic [POS_W-1:0]  code_pos;
  logic [LEN_W-1:0]  code_len;
  logic [DATA_W-1:0] chardata;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] char_nxt;
  logic              finish;
  logic              err;

  modport master (
    output code_valid, code_pos, code_len, chardata, out_ready,
    input  code_ready, out_valid, char_nxt, finish, err
  );

  modport slave (
    input  code_valid, code_pos, code_len, chardata, out_ready,
    output code_ready, out_valid, char_nxt, finish, err
  );
endinterface

// File: rtl/lz77_search_buffer.sv
// rtl/lz77_search_buffer.sv - shift-register history of emitted characters
module lz77_search_buffer #(
  parameter int DATA_W   = 8,
  parameter int SB_DEPTH = 30,
  parameter int IDX_W    = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              shift_en,
  input  logic [DATA_W-1:0] din,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data
);
  localparam int AW = $clog2(SB_DEPTH);

  logic [DATA_W-1:0] sb [SB_DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SB_DEPTH; i++) sb[i] <= '0;
    end else if (shift_en) begin
      sb[0] <= din;
      for (int i = 1; i < SB_DEPTH; i++) sb[i] <= sb[i-1];
    end
  end

  // Indices past the end of the history read as zero rather than aliasing.
  always_comb begin
    rd_data = '0;
    if (32'(rd_idx) < 32'(SB_DEPTH)) rd_data = sb[rd_idx[AW-1:0]];
  end
endmodule

// File: rtl/lz77_stream_decoder.sv
// rtl/lz77_stream_decoder.sv - expands (pos, len, literal) tokens into a character stream
module lz77_stream_decoder
  import lz77_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter int                SB_DEPTH = 30,
  parameter int                POS_W    = 5,
  parameter int                LEN_W    = 5,
  parameter logic [DATA_W-1:0] END_CHAR = DATA_W'(END_CHAR_DEFAULT)
) (
  input logic                  clk,
  input logic                  reset,
  lz77_stream_decoder_if.slave bus
);
  state_t            state, state_nxt;
  logic [POS_W-1:0]  pos_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [DATA_W-1:0] lit_q;
  logic              finish_q;
  logic              err_q;

  logic              code_ready_c;
  logic              out_valid_c;
  logic              accept;
  logic              out_hs;
  logic              at_lit;
  logic              lit_is_end;
  logic              pos_oob;
  logic [DATA_W-1:0] sb_rd;
  logic [DATA_W-1:0] char_c;

  assign at_lit     = (cnt_q == len_q);
  assign lit_is_end = (lit_q == END_CHAR);
  assign char_c     = at_lit ? lit_q : sb_rd;
  assign accept     = bus.code_valid && code_ready_c;
  assign out_hs     = out_valid_c && bus.out_ready;
  assign pos_oob    = 32'(bus.code_pos) >= 32'(SB_DEPTH);

  lz77_search_buffer #(
    .DATA_W   (DATA_W),
    .SB_DEPTH (SB_DEPTH),
    .IDX_W    (POS_W)
  ) u_sb (
    .clk      (clk),
    .reset    (reset),
    .shift_en (out_hs),
    .din      (char_c),
    .rd_idx   (pos_q),
    .rd_data  (sb_rd)
  );

  always_comb begin
    state_nxt    = state;
    code_ready_c = 1'b0;
    out_valid_c  = 1'b0;
    case (state)
      IDLE: begin
        code_ready_c = 1'b1;
        if (bus.code_valid) state_nxt = EMIT;
      end
      EMIT: begin
        out_valid_c  = 1'b1;
        // Next token is taken on the literal's handshake so tokens chain without a bubble.
        code_ready_c = at_lit && bus.out_ready && !lit_is_end;
        if (bus.out_ready && at_lit) begin
          if (lit_is_end)          state_nxt = DONE;
          else if (bus.code_valid) state_nxt = EMIT;
          else                     state_nxt = IDLE;
        end
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      pos_q    <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      lit_q    <= '0;
      finish_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        pos_q <= bus.code_pos;
        len_q <= bus.code_len;
        lit_q <= bus.chardata;
        cnt_q <= '0;
        if (bus.code_len != '0 && pos_oob) err_q <= 1'b1;
      end else if (out_hs && !at_lit) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (out_hs && at_lit && lit_is_end) finish_q <= 1'b1;
    end
  end

  assign bus.code_ready = code_ready_c;
  assign bus.out_valid  = out_valid_c;
  assign bus.char_nxt   = char_c;
  assign bus.finish     = finish_q;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_lz77_stream_decoder.sv
// tb/tb_lz77_stream_decoder.sv - directed self-checking bench for lz77_stream_decoder
module tb_lz77_stream_decoder;
  import lz77_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  lz77_stream_decoder_if #(.DATA_W(8), .POS_W(5), .LEN_W(5)) bus ();

  lz77_stream_decoder #(
    .DATA_W   (8),
    .SB_DEPTH (30),
    .POS_W    (5),
    .LEN_W    (5),
    .END_CHAR (8'h24)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  token_t     toks [40];
  logic [7:0] mb   [30];
  logic [7:0] exp_q[$];
  logic [7:0] ov_exp [6];
  logic [7:0] c;
  logic [7:0] held_val;
  logic       held;
  logic       ordy;
  int         ti;
  int         cyc;

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
  endtask

  // Inputs change at the falling edge; outputs are sampled 1ns later.
  task automatic drive(input logic v, input logic [4:0] pos, input logic [4:0] len,
                       input logic [7:0] lit, input logic rdy);
    bus.code_valid = v;
    bus.code_pos   = pos;
    bus.code_len   = len;
    bus.chardata   = lit;
    bus.out_ready  = rdy;
    #1;
  endtask

  task automatic next();
    @(negedge clk);
  endtask

  initial begin
    ov_exp = '{8'h61, 8'h62, 8'h61, 8'h62, 8'h61, 8'h78};
    bus.code_valid = 1'b0;
    bus.code_pos   = '0;
    bus.code_len   = '0;
    bus.chardata   = '0;
    bus.out_ready  = 1'b1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    drive(1'b0, 5'd0, 5'd0, 8'h00, 1'b1);
    check1("rst_code_ready", bus.code_ready, 1'b1);
    check1("rst_out_valid", bus.out_valid, 1'b0);
    check1("rst_finish", bus.finish, 1'b0);
    check1("rst_err", bus.err, 1'b0);
    check8("rst_char", bus.char_nxt, 8'h00);
    next();

    drive(1'b1, 5'd0, 5'd0, "a", 1'b1);
    check1("lit_idle_ready", bus.code_ready, 1'b1);
    next();
    drive(1'b1, 5'd0, 5'd0, "b", 1'b1);
    check8("lit_a", bus.char_nxt, "a");
    check1("lit_a_valid", bus.out_valid, 1'b1);
    check1("lit_a_ready", bus.code_ready, 1'b1);
    next();
    drive(1'b1, 5'd0, 5'd0, "c", 1'b1);
    check8("lit_b", bus.char_nxt, "b");
    check1("lit_b_valid", bus.out_valid, 1'b1);
    next();
    drive(1'b0, 5'd0, 5'd0, 8'h00, 1'b1);
    check8("lit_c", bus.char_nxt, "c");
    check1("lit_c_valid", bus.out_valid, 1'b1);
    next();
    drive(1'b0, 5'd0, 5'd0, 8'h00, 1'b1);
    check1("lit_idle_valid", bus.out_valid, 1'b0);
    next();

    drive(1'b1, 5'd0, 5'd0, "a", 1'b1);
    next();
    drive(1'b1, 5'd0, 5'd0, "b", 1'b1);
    check8("ov_pre_a", bus.char_nxt, "a");
    next();
    drive(1'b1, 5'd1, 5'd5, "x", 1'b1);
    check8("ov_pre_b", bus.char_nxt, "b");
    next();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 5'd0, 5'd0, 8'h00, 1'b1);
      check8($sformatf("ov_char%0d", i), bus.char_nxt, ov_exp[i]);
      check1($sformatf("ov_ready%0d", i), bus.code_ready, (i == 5));
      next();
    end

    // A zero-length token with an out-of-range position is legal.
    drive(1'b1, 5'd31, 5'd0, "q", 1'b1);
    next();
    drive(1'b0, 5'd0, 5'd0, 8'h00, 1'b1);
    check8("len0_char", bus.char_nxt, "q");
    check1("len0_err", bus.err, 1'b0);
    next();
    drive(1'b1, 5'd31, 5'd3, "z", 1'b1);
    next();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 5'd0, 5'd0, 8'h00, 1'b1);
      check8($sformatf("oob_char%0d", i), bus.char_nxt, (i < 3) ? 8'h00 : 8'h7a);
      check1($sformatf("oob_err%0d", i), bus.err, 1'b1);
      next();
    end

    reset = 1'b1;
    drive(1'b0, 5'd0, 5'd0, 8'h00, 1'b1);
    next();
    reset = 1'b0;
    for (int j = 0; j < 30; j++) mb[j] = 8'h00;
    for (int t = 0; t < 40; t++) begin
      toks[t].pos = 5'($urandom_range(0, 29));
      toks[t].len = 5'($urandom_range(0, 4));
      toks[t].lit = 8'($urandom_range(97, 122));
      for (int k = 0; k <= int'(toks[t].len); k++) begin
        c = (k == int'(toks[t].len)) ? toks[t].lit : mb[toks[t].pos];
        for (int j = 29; j > 0; j--) mb[j] = mb[j-1];
        mb[0] = c;
        exp_q.push_back(c);
      end
    end
    ti   = 0;
    cyc  = 0;
    held = 1'b0;
    while ((ti < 40 || exp_q.size() > 0) && cyc < 5000) begin
      ordy = ($urandom_range(0, 9) < 3);
      if (ti < 40) drive(1'b1, toks[ti].pos, toks[ti].len, toks[ti].lit, ordy);
      else         drive(1'b0, 5'd0, 5'd0, 8'h00, ordy);
      if (held) begin
        check1("bp_hold_valid", bus.out_valid, 1'b1);
        check8("bp_hold_char", bus.char_nxt, held_val);
      end
      held = 1'b0;
      if (bus.out_valid && !bus.out_ready) begin
        held     = 1'b1;
        held_val = bus.char_nxt;
      end
      if (bus.out_valid && bus.out_ready) begin
        check1("bp_expect_pending", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) check8("bp_char", bus.char_nxt, exp_q.pop_front());
      end
      if (bus.code_valid && bus.code_ready) ti++;
      next();
      cyc++;
    end
    check1("bp_stream_complete", (ti == 40) && (exp_q.size() == 0), 1'b1);

    reset = 1'b1;
    drive(1'b0, 5'd0, 5'd0, 8'h00, 1'b1);
    next();
    reset = 1'b0;
    drive(1'b1, 5'd0, 5'd0, "k", 1'b1);
    next();
    drive(1'b1, 5'd0, 5'd2, 8'h24, 1'b1);
    check8("term_k", bus.char_nxt, "k");
    next();
    drive(1'b1, 5'd0, 5'd0, "w", 1'b1);
    check8("term_copy0", bus.char_nxt, "k");
    check1("term_copy0_ready", bus.code_ready, 1'b0);
    next();
    drive(1'b1, 5'd0, 5'd0, "w", 1'b1);
    check8("term_copy1", bus.char_nxt, "k");
    next();
    drive(1'b1, 5'd0, 5'd0, "w", 1'b1);
    check8("term_lit", bus.char_nxt, 8'h24);
    check1("term_lit_ready", bus.code_ready, 1'b0);
    check1("term_lit_finish", bus.finish, 1'b0);
    next();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd0, 5'd0, "w", 1'b1);
      check1($sformatf("done_finish%0d", i), bus.finish, 1'b1);
      check1($sformatf("done_ready%0d", i), bus.code_ready, 1'b0);
      check1($sformatf("done_valid%0d", i), bus.out_valid, 1'b0);
      next();
    end

    reset = 1'b1;
    drive(1'b0, 5'd0, 5'd0, 8'h00, 1'b1);
    next();
    reset = 1'b0;
    drive(1'b1, 5'd31, 5'd6, "z", 1'b1);
    next();
    drive(1'b0, 5'd0, 5'd0, 8'h00, 1'b1);
    check8("mid_copy_char", bus.char_nxt, 8'h00);
    check1("mid_copy_err", bus.err, 1'b1);
    next();
    reset = 1'b1;
    drive(1'b0, 5'd0, 5'd0, 8'h00, 1'b1);
    next();
    reset = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 8'h00, 1'b1);
    check1("mid_rst_code_ready", bus.code_ready, 1'b1);
    check1("mid_rst_out_valid", bus.out_valid, 1'b0);
    check8("mid_rst_char", bus.char_nxt, 8'h00);
    check1("mid_rst_finish", bus.finish, 1'b0);
    check1("mid_rst_err", bus.err, 1'b0);
    next();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/lz77_stream_decoder.md
# lz77_stream_decoder

Parametrised LZ77 decoder. Consumes (position, length, literal) code tokens through a valid/ready handshake and expands each token into `length` copied characters plus one literal. It holds a shift-register search buffer of configurable depth and character width, and applies output backpressure. It sits between the code-token source and the character sink, and asserts a sticky `finish` once the configured terminator literal has been emitted.

## Interface
Parameters:
- `DATA_W`, 8: character width in bits.
- `SB_DEPTH`, 30: search-buffer depth in characters, range 2..32.
- `POS_W`, 5: `code_pos` width; must satisfy 2^POS_W >= SB_DEPTH.
- `LEN_W`, 5: `code_len` width.
- `END_CHAR`, 8'h24: terminator literal, sized to `DATA_W`.

Ports:
- `clk`, in, 1: the only clock, rising edge.
- `reset`, in, 1: synchronous, active-high. Reset is synchronous and active-high; there is one clock.
- `code_valid`, in, 1: a token is present on the code bus.
- `code_ready`, out, 1: the block accepts a token this cycle.
- `code_pos`, in, POS_W: copy offset into the search buffer; 0 = most recent character.
- `code_len`, in, LEN_W: number of characters to copy.
- `chardata`, in, DATA_W: literal emitted after the copy.
- `out_valid`, out, 1: `char_nxt` is valid.
- `out_ready`, in, 1: the sink accepts `char_nxt`.
- `char_nxt`, out, DATA_W: decoded character.
- `finish`, out, 1: terminator emitted; sticky until reset.
- `err`, out, 1: sticky; a token arrived with `code_len != 0` and `code_pos >= SB_DEPTH`.

## Operation
FSM states: IDLE, EMIT, DONE.
- **Token acceptance.** A token is accepted when `code_valid && code_ready`. The block latches pos/len/literal into registers and clears `cnt`.
- **IDLE.**
  - `code_ready=1`, `out_valid=0`.
  - On acceptance, go to EMIT.
- **EMIT.**
  - `out_valid=1`.
  - `char_nxt = (cnt==len) ? lit : sb[pos]`. Copied characters read index `pos` of the current buffer. Overlapping copies (pos < len) therefore self-replicate correctly.
  - Each output handshake (`out_valid && out_ready`):
    - shift the buffer (`sb[i] <= sb[i-1]`, `sb[0] <= char_nxt`, oldest dropped);
    - then `cnt <= cnt+1`.
  - Handshake with `cnt==len`, i.e. the literal is the emitted character:
    - if the literal == END_CHAR: go to DONE, `finish <= 1`;
    - otherwise: go to IDLE, unless a new token is accepted in the same cycle (see Timing), in which case stay in EMIT with the new token.
  - `code_ready = (cnt==len) && out_ready && (lit != END_CHAR)`. This gives back-to-back tokens with no bubble.
- **DONE.**
  - `code_ready=0`, `out_valid=0`, `finish=1`.
  - Held until reset.
- **Out-of-range position.** `pos >= SB_DEPTH` with `len != 0`: copied characters read as 0 and `err` is set. `len=0` ignores `pos` entirely.
- **Widths.** `cnt` is LEN_W bits wide and cannot wrap, because `cnt <= len`.

## Timing
Reset values (all outputs and state, applied by a synchronous `reset`):
- `code_ready=1`, `out_valid=0`, `char_nxt=0`, `finish=0`, `err=0`.
- Search buffer all zeros, state IDLE.

Cycle-level behaviour:
- **Latency.** Token accepted on edge T; first character is valid in cycle T+1.
- **Throughput.** A token produces len+1 characters in len+1 cycles when `out_ready=1` continuously. The next token can be accepted on the literal's handshake edge.
- **Backpressure.** With `out_ready=0`, `char_nxt` and all state hold, and `code_ready=0` in EMIT.
- **Reset mid-EMIT.** Discards the token and partial output and returns to the reset values on the next edge.
- **`code_valid` in DONE.** Ignored.

## Structure
- Package `lz77_pkg`:
  - state enum `{IDLE, EMIT, DONE}`;
  - default `END_CHAR`;
  - token struct `{pos, len, lit}`, parameterised by width localparams.
- One sub-module, `lz77_search_buffer`:
  - parameters DATA_W, SB_DEPTH;
  - ports: `shift_en`, `din`, `rd_idx`, `rd_data`;
  - out-of-range read returns 0.
- The top level holds the FSM, token registers and handshakes.

## Test plan
- **Reset.** Default params; hold `reset` 2 cycles. Expect `code_ready=1`, `out_valid=0`, `finish=0`, `err=0`.
- **Plain literals.** Tokens (0,0,'a'), (0,0,'b'), (0,0,'c') with `out_ready=1`. Expect `char_nxt` = 'a','b','c' on 3 consecutive cycles, with no bubble between tokens.
- **Overlapping copy.** After 'a','b', token (1,5,'x'). Expect a,b,a,b,a,x; `code_ready` is low for 5 cycles.
- **Backpressure.** Random `out_ready` duty (30%) over a 40-token stream. Expect the output sequence to be identical to the software model, and `char_nxt` stable while `out_valid && !out_ready`.
- **Terminator.** Token (0,2,8'h24). Expect 2 copies then `$`; `finish=1` on the next cycle and held; `code_ready=0` afterwards despite `code_valid=1`.
- **Errors and reset mid-operation.**
  - Token (31,3,'z'): expect 0,0,0,'z' and `err=1`.
  - Assert `reset` mid-copy: all outputs return to reset values on the next cycle.
